// File: rtl/pong_frame_ctrl_if.sv
// rtl/pong_frame_ctrl_if.sv - control inputs and frame-state outputs of the Pong frame sequencer
interface pong_frame_ctrl_if;
  logic       frame_tick;
  logic       start;
  logic       btn_l_up;
  logic       btn_l_dn;
  logic       btn_r_up;
  logic       btn_r_dn;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [9:0] pad_l_y;
  logic [9:0] pad_r_y;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic [1:0] game_state;
  logic       busy;

  modport master (
    output frame_tick, start, btn_l_up, btn_l_dn, btn_r_up, btn_r_dn,
    input  ball_x, ball_y, pad_l_y, pad_r_y, score_l, score_r, game_state, busy
  );

  modport slave (
    input  frame_tick, start, btn_l_up, btn_l_dn, btn_r_up, btn_r_dn,
    output ball_x, ball_y, pad_l_y, pad_r_y, score_l, score_r, game_state, busy
  );
endinterface

// File: rtl/pong_frame_ctrl.sv
// rtl/pong_frame_ctrl.sv - per-frame Pong sequencer: paddles, ball, collisions, scores
// All visible state commits on one edge so the renderer never sees a half-updated frame.
module pong_frame_ctrl #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int PADDLE_H     = 64,
  parameter int PADDLE_W     = 8,
  parameter int BALL_SIZE    = 8,
  parameter int LEFT_X       = 16,
  parameter int RIGHT_X      = 616,
  parameter int PADDLE_SPEED = 4,
  parameter int BALL_SPEED   = 2,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 9
) (
  input logic              clk,
  input logic              reset,
  pong_frame_ctrl_if.slave io
);

  typedef enum logic [1:0] {
    G_IDLE  = 2'd0,
    G_SERVE = 2'd1,
    G_PLAY  = 2'd2,
    G_OVER  = 2'd3
  } game_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PAD    = 3'd1,
    S_BALL   = 3'd2,
    S_CHECK  = 3'd3,
    S_COMMIT = 3'd4
  } seq_t;

  localparam int CW = $clog2(SERVE_FRAMES + 2);

  localparam logic [9:0]          CTR_X    = 10'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0]          CTR_Y    = 10'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0]          PAD_MID  = 10'((V_ACTIVE - PADDLE_H) / 2);
  localparam logic signed [10:0]  PAD_MAX  = 11'(V_ACTIVE - PADDLE_H);
  localparam logic signed [10:0]  P_SPD    = 11'(PADDLE_SPEED);
  localparam logic signed [10:0]  B_SPD    = 11'(BALL_SPEED);
  localparam logic signed [10:0]  B_SZ     = 11'(BALL_SIZE);
  localparam logic signed [10:0]  P_H      = 11'(PADDLE_H);
  localparam logic signed [10:0]  Y_MAX    = 11'(V_ACTIVE - BALL_SIZE);
  localparam logic signed [10:0]  X_MAX    = 11'(H_ACTIVE - BALL_SIZE);
  localparam logic signed [10:0]  L_FACE   = 11'(LEFT_X + PADDLE_W);
  localparam logic signed [10:0]  R_EDGE   = 11'(RIGHT_X);
  localparam logic signed [10:0]  R_STOP   = 11'(RIGHT_X - BALL_SIZE);
  localparam logic [3:0]          WIN      = 4'(WIN_SCORE);
  localparam logic [CW-1:0]       SERVE_LD = CW'(SERVE_FRAMES);

  game_t            gstate;
  seq_t             seq;
  logic             busy_q;
  logic [CW-1:0]    cnt;
  logic [9:0]       bx, by, pl, pr;
  logic [3:0]       sl, sr;
  logic             dx, dy;

  // Working copies built up across the sequence, only published in S_COMMIT.
  logic [9:0]       wpl, wpr;
  logic signed [10:0] nx, ny;
  logic [9:0]       cx, cy;
  logic             cdx, cdy, pt_l, pt_r;

  logic             ovl_l, ovl_r, hit_l, hit_r;
  logic [9:0]       k_x, k_y;
  logic             k_dx, k_dy, k_pt_l, k_pt_r;
  logic [3:0]       sl_inc, sr_inc;

  function automatic logic [9:0] pad_step(input logic [9:0] p, input logic up, input logic dn);
    logic signed [10:0] t;
    t = $signed({1'b0, p});
    if (up && !dn)
      t = t - P_SPD;
    else if (dn && !up)
      t = t + P_SPD;
    if (t < 11'sd0)
      t = '0;
    else if (t > PAD_MAX)
      t = PAD_MAX;
    return t[9:0];
  endfunction

  // dx: 1 = right, 0 = left.  dy: 1 = down, 0 = up.
  always_comb begin
    ovl_l  = (ny + B_SZ > $signed({1'b0, wpl})) && (ny < $signed({1'b0, wpl}) + P_H);
    ovl_r  = (ny + B_SZ > $signed({1'b0, wpr})) && (ny < $signed({1'b0, wpr}) + P_H);
    hit_l  = !dx && (nx <= L_FACE) && ovl_l;
    hit_r  = dx && (nx + B_SZ >= R_EDGE) && ovl_r;
    k_pt_r = !hit_l && !hit_r && (nx <= 11'sd0);
    k_pt_l = !hit_l && !hit_r && (nx >= X_MAX);
    k_x    = nx[9:0];
    k_dx   = dx;
    if (hit_l) begin
      k_x  = L_FACE[9:0];
      k_dx = 1'b1;
    end else if (hit_r) begin
      k_x  = R_STOP[9:0];
      k_dx = 1'b0;
    end else if (k_pt_r) begin
      k_dx = 1'b0;
    end else if (k_pt_l) begin
      k_dx = 1'b1;
    end
    k_y  = ny[9:0];
    k_dy = dy;
    if (ny <= 11'sd0) begin
      k_y  = '0;
      k_dy = 1'b1;
    end else if (ny >= Y_MAX) begin
      k_y  = Y_MAX[9:0];
      k_dy = 1'b0;
    end
  end

  assign sl_inc = (sl >= WIN) ? WIN : sl + 4'd1;
  assign sr_inc = (sr >= WIN) ? WIN : sr + 4'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gstate <= G_IDLE;
      seq    <= S_IDLE;
      busy_q <= 1'b0;
      cnt    <= '0;
      bx     <= CTR_X;
      by     <= CTR_Y;
      pl     <= PAD_MID;
      pr     <= PAD_MID;
      sl     <= '0;
      sr     <= '0;
      dx     <= 1'b1;
      dy     <= 1'b1;
      wpl    <= PAD_MID;
      wpr    <= PAD_MID;
      nx     <= '0;
      ny     <= '0;
      cx     <= '0;
      cy     <= '0;
      cdx    <= 1'b1;
      cdy    <= 1'b1;
      pt_l   <= 1'b0;
      pt_r   <= 1'b0;
    end else if (!busy_q) begin
      // A start accepted together with a frame_tick changes state first; the sequence then sees SERVE.
      if (io.start && (gstate == G_IDLE || gstate == G_OVER)) begin
        gstate <= G_SERVE;
        cnt    <= SERVE_LD;
        bx     <= CTR_X;
        by     <= CTR_Y;
        if (gstate == G_OVER) begin
          sl <= '0;
          sr <= '0;
        end
      end
      if (io.frame_tick) begin
        seq    <= S_PAD;
        busy_q <= 1'b1;
      end
    end else begin
      case (seq)
        S_PAD: begin
          if (gstate != G_OVER) begin
            wpl <= pad_step(pl, io.btn_l_up, io.btn_l_dn);
            wpr <= pad_step(pr, io.btn_r_up, io.btn_r_dn);
          end else begin
            wpl <= pl;
            wpr <= pr;
          end
          seq <= S_BALL;
        end
        S_BALL: begin
          if (gstate == G_PLAY) begin
            nx <= dx ? $signed({1'b0, bx}) + B_SPD : $signed({1'b0, bx}) - B_SPD;
            ny <= dy ? $signed({1'b0, by}) + B_SPD : $signed({1'b0, by}) - B_SPD;
          end
          seq <= S_CHECK;
        end
        S_CHECK: begin
          cx   <= k_x;
          cy   <= k_y;
          cdx  <= k_dx;
          cdy  <= k_dy;
          pt_l <= k_pt_l;
          pt_r <= k_pt_r;
          seq  <= S_COMMIT;
        end
        S_COMMIT: begin
          pl <= wpl;
          pr <= wpr;
          if (gstate == G_SERVE) begin
            if (cnt > CW'(1)) begin
              cnt <= cnt - CW'(1);
            end else begin
              cnt    <= '0;
              gstate <= G_PLAY;
            end
          end else if (gstate == G_PLAY) begin
            dx <= cdx;
            dy <= cdy;
            if (pt_l || pt_r) begin
              if (pt_l) sl <= sl_inc;
              if (pt_r) sr <= sr_inc;
              bx <= CTR_X;
              by <= CTR_Y;
              if ((pt_l && sl_inc >= WIN) || (pt_r && sr_inc >= WIN)) begin
                gstate <= G_OVER;
              end else begin
                gstate <= G_SERVE;
                cnt    <= SERVE_LD;
              end
            end else begin
              bx <= cx;
              by <= cy;
            end
          end
          seq    <= S_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          seq    <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign io.ball_x     = bx;
  assign io.ball_y     = by;
  assign io.pad_l_y    = pl;
  assign io.pad_r_y    = pr;
  assign io.score_l    = sl;
  assign io.score_r    = sr;
  assign io.game_state = gstate;
  assign io.busy       = busy_q;

endmodule

// File: tb/tb_pong_frame_ctrl.sv
// tb/tb_pong_frame_ctrl.sv - directed bench for pong_frame_ctrl (SERVE_FRAMES=2, WIN_SCORE=2)
module tb_pong_frame_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  pong_frame_ctrl_if bus ();

  pong_frame_ctrl #(
    .SERVE_FRAMES(2),
    .WIN_SCORE   (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .io   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic frame();
    int n;
    @(negedge clk);
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    n = 0;
    while (bus.busy === 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10) check("busy_timeout", 32'(bus.busy), 0);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic check_ball(input string tag, input int x, input int y);
    check({tag, "_x"}, 32'(bus.ball_x), x);
    check({tag, "_y"}, 32'(bus.ball_y), y);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int e;
    reset          = 1'b0;
    bus.frame_tick = 1'b0;
    bus.start      = 1'b0;
    bus.btn_l_up   = 1'b0;
    bus.btn_l_dn   = 1'b0;
    bus.btn_r_up   = 1'b0;
    bus.btn_r_dn   = 1'b0;
    repeat (3) @(negedge clk);
    check_ball("rst_ball", 316, 236);
    check("rst_pad_l", 32'(bus.pad_l_y), 208);
    check("rst_pad_r", 32'(bus.pad_r_y), 208);
    check("rst_score_l", 32'(bus.score_l), 0);
    check("rst_score_r", 32'(bus.score_r), 0);
    check("rst_state", 32'(bus.game_state), 0);
    check("rst_busy", 32'(bus.busy), 0);
    reset = 1'b1;

    // Left paddle climbs to the top clamp; right paddle with both buttons stays put.
    bus.btn_l_up = 1'b1;
    bus.btn_r_up = 1'b1;
    bus.btn_r_dn = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      frame();
      e = 208 - 4 * i;
      if (e < 0) e = 0;
      check("pad_l_up", 32'(bus.pad_l_y), e);
      check("pad_r_both", 32'(bus.pad_r_y), 208);
    end
    bus.btn_l_up = 1'b0;
    bus.btn_r_up = 1'b0;
    frames(46);
    bus.btn_r_dn = 1'b0;
    check("pad_r_dn", 32'(bus.pad_r_y), 392);
    check_ball("idle_ball", 316, 236);
    check("idle_state", 32'(bus.game_state), 0);

    // Start and serve countdown.
    @(negedge clk);
    bus.start = 1'b1;
    check("pre_start_state", 32'(bus.game_state), 0);
    @(negedge clk);
    bus.start = 1'b0;
    check("start_state", 32'(bus.game_state), 1);
    frame();
    check("serve1_state", 32'(bus.game_state), 1);
    frame();
    check("serve2_state", 32'(bus.game_state), 2);
    check_ball("serve_end", 316, 236);
    frame();
    check_ball("play_k1", 318, 238);
    pulse_start();
    check("start_in_play", 32'(bus.game_state), 2);

    // Rally 1: bottom wall, right paddle hit, top wall, left miss past the parked paddle.
    frames(117);
    check_ball("r1_bottom", 552, 472);
    frames(28);
    check_ball("r1_rhit", 608, 416);
    frame();
    check_ball("r1_after_rhit", 606, 414);
    frames(303);
    check("r1_score_r", 32'(bus.score_r), 1);
    check("r1_score_l", 32'(bus.score_l), 0);
    check("r1_state", 32'(bus.game_state), 1);
    check_ball("r1_centre", 316, 236);

    // Rally 2: serve leftward, left paddle moved into line, top wall bounce, right miss.
    bus.btn_l_dn = 1'b1;
    frames(98);
    bus.btn_l_dn = 1'b0;
    check("r2_pad_l", 32'(bus.pad_l_y), 392);
    check_ball("r2_k96", 124, 428);
    frames(49);
    check_ball("r2_k145", 26, 418);
    frame();
    check_ball("r2_lhit", 24, 416);
    frame();
    check_ball("r2_after_lhit", 26, 414);
    frames(206);
    check_ball("r2_near_top", 438, 2);
    frame();
    check_ball("r2_top", 440, 0);
    frame();
    check_ball("r2_after_top", 442, 2);
    frames(95);
    check("r2_score_l", 32'(bus.score_l), 1);
    check("r2_score_r", 32'(bus.score_r), 1);
    check("r2_state", 32'(bus.game_state), 1);

    // Rally 3: replay of rally 1, second left miss ends the game.
    frames(2);
    check("r3_play", 32'(bus.game_state), 2);
    frames(146);
    check_ball("r3_rhit", 608, 416);
    frames(304);
    check("r3_state", 32'(bus.game_state), 3);
    check("r3_score_r", 32'(bus.score_r), 2);
    check("r3_score_l", 32'(bus.score_l), 1);

    // Second frame_tick while busy must be ignored: busy spans exactly 4 cycles.
    @(negedge clk);
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    check("busy_c1", 32'(bus.busy), 1);
    @(negedge clk);
    check("busy_c2", 32'(bus.busy), 1);
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    check("busy_c3", 32'(bus.busy), 1);
    @(negedge clk);
    check("busy_c4", 32'(bus.busy), 1);
    @(negedge clk);
    check("busy_c5", 32'(bus.busy), 0);
    repeat (4) @(negedge clk);
    check("busy_stays_low", 32'(bus.busy), 0);
    check("over_pad_l", 32'(bus.pad_l_y), 392);

    // Restart from OVER clears scores.
    pulse_start();
    check("restart_state", 32'(bus.game_state), 1);
    check("restart_score_l", 32'(bus.score_l), 0);
    check("restart_score_r", 32'(bus.score_r), 0);

    // Reset asserted mid-sequence takes effect immediately.
    @(negedge clk);
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    check("midseq_busy", 32'(bus.busy), 1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_busy", 32'(bus.busy), 0);
    check("arst_state", 32'(bus.game_state), 0);
    check("arst_pad_l", 32'(bus.pad_l_y), 208);
    check("arst_pad_r", 32'(bus.pad_r_y), 208);
    check_ball("arst_ball", 316, 236);
    @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    check("post_rst_busy", 32'(bus.busy), 0);
    bus.btn_r_up = 1'b1;
    frame();
    bus.btn_r_up = 1'b0;
    check("post_rst_pad_r", 32'(bus.pad_r_y), 204);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
